// File: rtl/csr_unit.sv
// Machine-mode CSR file for the OTTER core.
// Holds mstatus, mtvec, mepc and mcause; handles trap entry, MRET and CSRRW/S/C write-back.
module csr_unit #(
   parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
   parameter logic [31:0] MCAUSE_INTR = 32'h8000_000B
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CSR_WE,
   input  logic [11:0] ADDR,
   input  logic [31:0] WD,
   input  logic [31:0] PC,
   input  logic        INT_TAKEN,
   input  logic        MRET_EXEC,
   output logic [31:0] RD,
   output logic [31:0] MTVEC,
   output logic [31:0] MEPC,
   output logic        CSR_MSTATUS_MIE
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   // Only MIE and MPIE exist in mstatus; every other bit is hard-wired to zero.
   logic        mie;
   logic        mpie;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic [31:0] mcause;
   logic [31:0] mstatus;

   assign mstatus = {24'h0, mpie, 3'b000, mie, 3'b000};

   // One update per edge: reset, then trap entry, then MRET, then the CSR write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         mie    <= 1'b0;
         mpie   <= 1'b0;
         mtvec  <= MTVEC_RST;
         mepc   <= 32'h0;
         mcause <= 32'h0;
      end else if (INT_TAKEN) begin
         mepc   <= {PC[31:2], 2'b00};
         mcause <= MCAUSE_INTR;
         mpie   <= mie;
         mie    <= 1'b0;
      end else if (MRET_EXEC) begin
         mie    <= mpie;
         mpie   <= 1'b1;
      end else if (CSR_WE) begin
         case (ADDR)
            ADDR_MSTATUS: begin
               mie  <= WD[3];
               mpie <= WD[7];
            end
            ADDR_MTVEC:  mtvec  <= {WD[31:2], 2'b00};
            ADDR_MEPC:   mepc   <= {WD[31:2], 2'b00};
            ADDR_MCAUSE: mcause <= WD;
            default: ;
         endcase
      end
   end

   always_comb begin
      RD = 32'h0;
      case (ADDR)
         ADDR_MSTATUS: RD = mstatus;
         ADDR_MTVEC:   RD = mtvec;
         ADDR_MEPC:    RD = mepc;
         ADDR_MCAUSE:  RD = mcause;
         default:      RD = 32'h0;
      endcase
   end

   assign MTVEC           = mtvec;
   assign MEPC            = mepc;
   assign CSR_MSTATUS_MIE = mie;

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed trap/MRET/collision scenarios plus random traffic,
// compared every cycle against a register-level model of the CSR file.
module tb_csr_unit;

   localparam logic [31:0] TB_MTVEC_RST = 32'h0000_1000;
   localparam logic [31:0] TB_CAUSE     = 32'h8000_000B;

   logic        clk;
   logic        rst;
   logic        csr_we;
   logic [11:0] addr;
   logic [31:0] wd;
   logic [31:0] pc;
   logic        int_taken;
   logic        mret_exec;
   logic [31:0] rd;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        mie;

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic check_en = 1'b0;

   // model state: architectural register values as software sees them
   logic [31:0] m_mstatus = 32'h0;
   logic [31:0] m_mtvec   = 32'h0;
   logic [31:0] m_mepc    = 32'h0;
   logic [31:0] m_mcause  = 32'h0;

   csr_unit #(.MTVEC_RST(TB_MTVEC_RST), .MCAUSE_INTR(TB_CAUSE)) dut (
      .CLK(clk), .RST(rst), .CSR_WE(csr_we), .ADDR(addr), .WD(wd), .PC(pc),
      .INT_TAKEN(int_taken), .MRET_EXEC(mret_exec), .RD(rd), .MTVEC(mtvec),
      .MEPC(mepc), .CSR_MSTATUS_MIE(mie)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         default: return 32'h0;
      endcase
   endfunction

   // reference model: apply the single highest-priority event of this edge
   always @(posedge clk) begin
      if (rst) begin
         m_mtvec = TB_MTVEC_RST; m_mstatus = 0; m_mepc = 0; m_mcause = 0;
      end else if (int_taken) begin
         m_mepc    = pc & ~32'h3;
         m_mcause  = TB_CAUSE;
         m_mstatus = m_mstatus[3] ? 32'h80 : 32'h00;
      end else if (mret_exec) begin
         m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h08 : 32'h00);
      end else if (csr_we) begin
         case (addr)
            12'h300: m_mstatus = wd & 32'h88;
            12'h305: m_mtvec   = wd & ~32'h3;
            12'h341: m_mepc    = wd & ~32'h3;
            12'h342: m_mcause  = wd;
            default: ;
         endcase
      end
   end

   // scoreboard compare, mid-cycle
   always @(negedge clk) begin
      if (check_en) begin
         chk("mtvec", mtvec, m_mtvec);
         chk("mepc", mepc, m_mepc);
         chk("mie", {31'h0, mie}, {31'h0, m_mstatus[3]});
         chk("rd", rd, model_read(addr));
      end
   end

   // driver tasks
   task automatic drive(input logic r, input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] p, input logic it, input logic mr);
      rst = r; csr_we = we; addr = a; wd = d; pc = p; int_taken = it; mret_exec = mr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_is(input string name, input logic [11:0] a, input logic [31:0] exp);
      drive(1'b0, 1'b0, a, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk(name, rd, exp);
   endtask

   function automatic logic [11:0] pick_addr();
      case ($urandom_range(0, 5))
         0: return 12'h300;
         1: return 12'h305;
         2: return 12'h341;
         3: return 12'h342;
         default: return 12'($urandom_range(0, 4095));
      endcase
   endfunction

   initial begin
      // reset with arbitrary other inputs, including a trap pulse
      drive(1'b1, 1'b1, 12'h341, 32'hFFFF_FFFF, 32'h0000_0abc, 1'b1, 1'b1);
      tick();
      check_en = 1'b1;
      drive(1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      chk("rst_mtvec", mtvec, 32'h0000_1000);
      chk("rst_mepc", mepc, 32'h0);
      chk("rst_mie", {31'h0, mie}, 32'h0);
      rd_is("rst_mcause", 12'h342, 32'h0);

      drive(1'b0, 1'b1, 12'h305, 32'h0000_0103, 32'h0, 1'b0, 1'b0);
      tick();
      chk("wr_mtvec", mtvec, 32'h0000_0100);

      drive(1'b0, 1'b1, 12'h300, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
      tick();
      chk("wr_mstatus_mie", {31'h0, mie}, 32'h1);
      rd_is("wr_mstatus_rd", 12'h300, 32'h0000_0088);

      drive(1'b0, 1'b1, 12'h123, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
      tick();
      rd_is("unmapped_rd", 12'h123, 32'h0);
      chk("unmapped_mtvec", mtvec, 32'h0000_0100);
      chk("unmapped_mepc", mepc, 32'h0);

      drive(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0040, 1'b1, 1'b0);
      tick();
      chk("trap_mepc", mepc, 32'h0000_0040);
      chk("trap_mie", {31'h0, mie}, 32'h0);
      rd_is("trap_mcause", 12'h342, 32'h8000_000B);
      rd_is("trap_mstatus", 12'h300, 32'h0000_0080);

      drive(1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0, 1'b1);
      tick();
      chk("mret_mie", {31'h0, mie}, 32'h1);
      chk("mret_mepc", mepc, 32'h0000_0040);
      rd_is("mret_mstatus", 12'h300, 32'h0000_0088);

      drive(1'b0, 1'b1, 12'h341, 32'h0000_1234, 32'h0000_0080, 1'b1, 1'b0);
      tick();
      chk("coll_we_mepc", mepc, 32'h0000_0080);

      // MIE is 0, MPIE is 1 here: a winning MRET would set MIE
      drive(1'b0, 1'b0, 12'h000, 32'h0, 32'h0000_0103, 1'b1, 1'b1);
      tick();
      chk("coll_mret_mepc", mepc, 32'h0000_0100);
      chk("coll_mret_mie", {31'h0, mie}, 32'h0);
      rd_is("coll_mret_mstatus", 12'h300, 32'h0);

      drive(1'b1, 1'b0, 12'h000, 32'h0, 32'h0000_0044, 1'b1, 1'b0);
      tick();
      chk("rst_trap_mepc", mepc, 32'h0);
      chk("rst_trap_mtvec", mtvec, 32'h0000_1000);
      chk("rst_trap_mie", {31'h0, mie}, 32'h0);
      rd_is("rst_trap_mcause", 12'h342, 32'h0);

      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, pick_addr(), $urandom(),
               $urandom(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
         tick();
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Machine-mode CSR file for the OTTER RISC-V core. Holds mstatus, mtvec, mepc and mcause, and services CSRRW/CSRRS/CSRRC write-backs from the datapath. On interrupt entry it saves the PC and disables interrupts; on MRET it restores them. Its MTVEC and MEPC outputs feed the PC source mux directly, and CSR_MSTATUS_MIE feeds the control FSM's interrupt gating.

Parameters:
MTVEC_RST, 32'h0000_0000, reset value of mtvec
MCAUSE_INTR, 32'h8000_000B, value loaded into mcause on interrupt entry (machine external interrupt)

Ports:
CLK  in  1  system clock, all state updates on rising edge
RST  in  1  synchronous, active-high reset
CSR_WE  in  1  commit WD to the CSR selected by ADDR this cycle
ADDR  in  12  CSR address (instruction bits [31:20])
WD  in  32  write data, already combined by the ALU for RS/RC
PC  in  32  address of the instruction being interrupted
INT_TAKEN  in  1  one-cycle pulse from the control FSM: enter trap
MRET_EXEC  in  1  one-cycle pulse from the control FSM: execute MRET
RD  out  32  combinational read of the CSR at ADDR
MTVEC  out  32  current mtvec, to the PC mux
MEPC  out  32  current mepc, to the PC mux
CSR_MSTATUS_MIE  out  1  mstatus.MIE, to the control FSM

Behaviour:
- Address map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause.
- Reset at the CLK edge with RST=1:
  - mtvec = MTVEC_RST.
  - mstatus, mepc and mcause = 0.
  - Resulting outputs: MTVEC = MTVEC_RST, MEPC = 0, CSR_MSTATUS_MIE = 0.
  - RST overrides every other input in the same cycle, including a trap in progress.
- Update priority per edge: RST > INT_TAKEN > MRET_EXEC > CSR_WE. Only the highest-priority event takes effect. A CSR write coinciding with INT_TAKEN or MRET_EXEC is dropped and not deferred.
- INT_TAKEN:
  - mepc <= {PC[31:2], 2'b00}
  - mcause <= MCAUSE_INTR
  - mstatus.MPIE (bit 7) <= mstatus.MIE (bit 3)
  - mstatus.MIE <= 0
- MRET_EXEC:
  - mstatus.MIE <= mstatus.MPIE
  - mstatus.MPIE <= 1
  - mepc and mcause unchanged.
- CSR_WE:
  - 0x300: only bits 3 and 7 are writable. All other mstatus bits read 0 at all times.
  - 0x305: mtvec <= {WD[31:2], 2'b00}.
  - 0x341: mepc <= {WD[31:2], 2'b00}.
  - 0x342: mcause <= WD (full 32 bits).
  - Any other address: write ignored, no state change.
- RD is purely combinational from ADDR and current state. It returns 0 for unmapped addresses. It shows the pre-write value in the same cycle as a write, and the new value from the next cycle.
- MTVEC, MEPC and CSR_MSTATUS_MIE are registered values with zero combinational path from inputs. An update is visible one cycle after the triggering edge.
- Back-to-back INT_TAKEN pulses (nested entry) are legal. The second entry overwrites mepc and copies the now-0 MIE into MPIE.
- If INT_TAKEN and MRET_EXEC are asserted in the same cycle, INT_TAKEN wins and MRET is lost.

Test Plan:
- Reset: drive RST=1 for 1 cycle with arbitrary inputs -> MTVEC=MTVEC_RST, MEPC=0, CSR_MSTATUS_MIE=0, RD@0x342=0.
- CSR writes: CSR_WE with ADDR=0x305, WD=0x0000_0103 -> next cycle MTVEC=0x0000_0100. ADDR=0x300, WD=0xFFFF_FFFF -> RD@0x300=0x0000_0088 and MIE=1. ADDR=0x123, WD=0xDEAD_BEEF -> no register changes and RD@0x123=0.
- Trap entry: MIE=1, PC=0x0000_0040, INT_TAKEN pulse -> MEPC=0x40, RD@0x342=0x8000_000B, MIE=0, RD@0x300=0x80.
- MRET: then MRET_EXEC pulse -> MIE=1, RD@0x300=0x88, MEPC still 0x40.
- Collision: INT_TAKEN and CSR_WE(0x341, WD=0x1234) in the same cycle with PC=0x80 -> MEPC=0x80, write dropped. INT_TAKEN and MRET_EXEC together -> trap-entry result only.
- Mid-trap reset: INT_TAKEN and RST in the same cycle -> all reset values, MEPC=0.
